// File: rtl/sd_init_pkg.sv
// Shared definitions for sd_init_sequencer: step/state encodings, SD command
// indices, fixed arguments, CMD8 echo pattern and error codes.
package sd_init_pkg;

  typedef enum logic [3:0] {
    S_CMD0,
    S_CMD8,
    S_CMD55,
    S_ACMD41,
    S_CMD2,
    S_CMD3,
    S_CMD7,
    S_CMD55W,
    S_ACMD6
  } step_e;

  typedef enum logic [3:0] {
    ST_POWER_UP,
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_WAIT_DONE,
    ST_CHECK,
    ST_DRV_RST,
    ST_DONE,
    ST_ERROR
  } state_e;

  localparam logic [5:0] CMD_GO_IDLE   = 6'd0;
  localparam logic [5:0] CMD_SEND_IF   = 6'd8;
  localparam logic [5:0] CMD_APP       = 6'd55;
  localparam logic [5:0] CMD_SD_OP     = 6'd41;
  localparam logic [5:0] CMD_ALL_CID   = 6'd2;
  localparam logic [5:0] CMD_SEND_RCA  = 6'd3;
  localparam logic [5:0] CMD_SELECT    = 6'd7;
  localparam logic [5:0] CMD_BUS_WIDTH = 6'd6;

  localparam logic [31:0] CMD8_ARG    = 32'h0000_01AA;
  localparam logic [11:0] CMD8_CHECK  = 12'h1AA;
  localparam logic [31:0] ACMD6_ARG   = 32'h0000_0002;

  localparam logic [2:0] ERR_NONE          = 3'd0;
  localparam logic [2:0] ERR_CMD8_TIMEOUT  = 3'd1;
  localparam logic [2:0] ERR_CMD8_ECHO     = 3'd2;
  localparam logic [2:0] ERR_ACMD41_RETRY  = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT       = 3'd4;

  function automatic logic [5:0] step_index(step_e s);
    case (s)
      S_CMD0:   return CMD_GO_IDLE;
      S_CMD8:   return CMD_SEND_IF;
      S_CMD55:  return CMD_APP;
      S_ACMD41: return CMD_SD_OP;
      S_CMD2:   return CMD_ALL_CID;
      S_CMD3:   return CMD_SEND_RCA;
      S_CMD7:   return CMD_SELECT;
      S_CMD55W: return CMD_APP;
      S_ACMD6:  return CMD_BUS_WIDTH;
      default:  return CMD_GO_IDLE;
    endcase
  endfunction

  function automatic logic [31:0] step_arg(step_e s, logic [15:0] rca,
                                           logic [31:0] acmd41_arg);
    case (s)
      S_CMD8:   return CMD8_ARG;
      S_ACMD41: return acmd41_arg;
      S_CMD7:   return {rca, 16'h0000};
      S_CMD55W: return {rca, 16'h0000};
      S_ACMD6:  return ACMD6_ARG;
      default:  return 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/sd_init_sequencer.sv
// SD card initialisation sequencer: CMD0, CMD8, CMD55/ACMD41 loop, CMD2, CMD3, CMD7.
// Define SD_INIT_WIDE_BUS_EN to append CMD55 + ACMD6 (4-bit bus) before DONE.
module sd_init_sequencer
  import sd_init_pkg::*;
#(
  parameter int unsigned INIT_CYCLES    = 80,
  parameter int unsigned RESP_TIMEOUT   = 512,
  parameter int unsigned ACMD41_RETRIES = 1023,
  parameter logic [31:0] ACMD41_ARG     = 32'h40FF_8000
) (
  input  logic        iclk,
  input  logic        irst_n,
  input  logic        istart,
  output logic        ocmd_start,
  output logic [5:0]  ocmd_index,
  output logic [31:0] ocmd_arg,
  output logic        odrv_rst,
  input  logic [31:0] iresp,
  input  logic        icmd_done,
  output logic        oinit_done,
  output logic        oerror,
  output logic [2:0]  oerr_code,
  output logic [15:0] orca,
  output logic        ohcs
);

  localparam int unsigned INIT_W  = $clog2(INIT_CYCLES + 1);
  localparam int unsigned TMO_W   = $clog2(RESP_TIMEOUT + 1);
  localparam int unsigned RETRY_W = $clog2(ACMD41_RETRIES + 1);

  localparam logic [INIT_W-1:0]  INIT_LAST  = INIT_W'(INIT_CYCLES - 1);
  localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(RESP_TIMEOUT - 1);
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(ACMD41_RETRIES - 1);

  state_e              state_q, state_d;
  step_e               step_q, step_d;
  logic [INIT_W-1:0]   init_cnt_q, init_cnt_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [RETRY_W-1:0]  retry_q, retry_d;
  logic                rst_cnt_q, rst_cnt_d;
  logic                pend_q, pend_d;
  logic [2:0]          err_q, err_d;
  logic [15:0]         rca_q, rca_d;
  logic                hcs_q, hcs_d;
  logic                istart_q, istart_prev_q;
  logic                start_rise;
  logic                unused_resp;

  assign start_rise  = istart_q & ~istart_prev_q;
  assign unused_resp = ^iresp[15:12];

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    init_cnt_d = init_cnt_q;
    tmo_d      = tmo_q;
    retry_d    = retry_q;
    rst_cnt_d  = rst_cnt_q;
    pend_d     = pend_q;
    err_d      = err_q;
    rca_d      = rca_q;
    hcs_d      = hcs_q;

    case (state_q)
      ST_POWER_UP: begin
        if (start_rise) pend_d = 1'b1;
        if (init_cnt_q == INIT_LAST) begin
          state_d = ST_IDLE;
        end else begin
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end

      ST_IDLE: begin
        if (start_rise || pend_q) begin
          pend_d  = 1'b0;
          step_d  = S_CMD0;
          retry_d = '0;
          rca_d   = '0;
          hcs_d   = 1'b0;
          tmo_d   = '0;
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        tmo_d   = tmo_q + 1'b1;
        state_d = ST_WAIT_ACK;
      end

      ST_WAIT_ACK: begin
        tmo_d = tmo_q + 1'b1;
        if (tmo_q >= TMO_LAST) begin
          rst_cnt_d = 1'b0;
          state_d   = ST_DRV_RST;
        end else if (!icmd_done) begin
          state_d = ST_WAIT_DONE;
        end
      end

      ST_WAIT_DONE: begin
        tmo_d = tmo_q + 1'b1;
        if (tmo_q >= TMO_LAST) begin
          rst_cnt_d = 1'b0;
          state_d   = ST_DRV_RST;
        end else if (icmd_done) begin
          state_d = ST_CHECK;
        end
      end

      ST_DRV_RST: begin
        if (rst_cnt_q) begin
          rst_cnt_d = 1'b0;
          case (step_q)
            // CMD0 never gets a response, so its timeout is the normal exit.
            S_CMD0: begin
              step_d  = S_CMD8;
              tmo_d   = '0;
              state_d = ST_ISSUE;
            end
            S_CMD8: begin
              err_d   = ERR_CMD8_TIMEOUT;
              state_d = ST_ERROR;
            end
            default: begin
              err_d   = ERR_TIMEOUT;
              state_d = ST_ERROR;
            end
          endcase
        end else begin
          rst_cnt_d = 1'b1;
        end
      end

      ST_CHECK: begin
        tmo_d   = '0;
        state_d = ST_ISSUE;
        case (step_q)
          S_CMD0:  step_d = S_CMD8;
          S_CMD8: begin
            if (iresp[11:0] == CMD8_CHECK) begin
              step_d = S_CMD55;
            end else begin
              err_d   = ERR_CMD8_ECHO;
              state_d = ST_ERROR;
            end
          end
          S_CMD55: step_d = S_ACMD41;
          S_ACMD41: begin
            if (iresp[31]) begin
              hcs_d  = iresp[30];
              step_d = S_CMD2;
            end else if (retry_q == RETRY_LAST) begin
              err_d   = ERR_ACMD41_RETRY;
              state_d = ST_ERROR;
            end else begin
              retry_d = retry_q + 1'b1;
              step_d  = S_CMD55;
            end
          end
          S_CMD2: step_d = S_CMD3;
          S_CMD3: begin
            rca_d  = iresp[31:16];
            step_d = S_CMD7;
          end
          S_CMD7: begin
`ifdef SD_INIT_WIDE_BUS_EN
            step_d = S_CMD55W;
`else
            state_d = ST_DONE;
`endif
          end
          S_CMD55W: step_d = S_ACMD6;
          S_ACMD6:  state_d = ST_DONE;
          default: begin
            err_d   = ERR_TIMEOUT;
            state_d = ST_ERROR;
          end
        endcase
      end

      ST_DONE, ST_ERROR: begin
        if (start_rise) begin
          err_d   = ERR_NONE;
          step_d  = S_CMD0;
          retry_d = '0;
          rca_d   = '0;
          hcs_d   = 1'b0;
          tmo_d   = '0;
          state_d = ST_ISSUE;
        end
      end

      default: state_d = ST_POWER_UP;
    endcase
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_q       <= ST_POWER_UP;
      step_q        <= S_CMD0;
      init_cnt_q    <= '0;
      tmo_q         <= '0;
      retry_q       <= '0;
      rst_cnt_q     <= 1'b0;
      pend_q        <= 1'b0;
      err_q         <= ERR_NONE;
      rca_q         <= '0;
      hcs_q         <= 1'b0;
      istart_q      <= 1'b0;
      istart_prev_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      step_q        <= step_d;
      init_cnt_q    <= init_cnt_d;
      tmo_q         <= tmo_d;
      retry_q       <= retry_d;
      rst_cnt_q     <= rst_cnt_d;
      pend_q        <= pend_d;
      err_q         <= err_d;
      rca_q         <= rca_d;
      hcs_q         <= hcs_d;
      istart_q      <= istart;
      istart_prev_q <= istart_q;
    end
  end

  // Index/arg decode from the step register, which only moves on CHECK/DRV_RST
  // exit, so they stay stable across response reception and CRC retries.
  assign ocmd_index = step_index(step_q);
  assign ocmd_arg   = step_arg(step_q, rca_q, ACMD41_ARG);
  assign ocmd_start = (state_q == ST_ISSUE);
  assign odrv_rst   = ~irst_n | (state_q == ST_DRV_RST);
  assign oinit_done = (state_q == ST_DONE);
  assign oerror     = (state_q == ST_ERROR);
  assign oerr_code  = err_q;
  assign orca       = rca_q;
  assign ohcs       = hcs_q;

endmodule

// File: tb/tb_sd_init_sequencer.sv
// Directed bench for sd_init_sequencer with a behavioural cmd_driver/card model.
module tb_sd_init_sequencer;

  logic        clk = 1'b0;
  logic        irst_n;
  logic        istart;
  logic        ocmd_start;
  logic [5:0]  ocmd_index;
  logic [31:0] ocmd_arg;
  logic        odrv_rst;
  logic [31:0] iresp = '0;
  logic        icmd_done = 1'b0;
  logic        oinit_done;
  logic        oerror;
  logic [2:0]  oerr_code;
  logic [15:0] orca;
  logic        ohcs;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Card model configuration (written by the stimulus only)
  logic [11:0] cmd8_echo = 12'h1AA;
  logic        cmd8_respond = 1'b1;
  logic        always_busy = 1'b0;
  int          busy_n = 2;
  logic        ccs = 1'b1;

  // Model-owned state
  int          phase = 0;
  int          a41_cnt = 0;
  int          width_err = 0;
  int          stab_err = 0;
  logic [5:0]  cur_idx;
  logic [31:0] cur_arg;
  logic [5:0]  cmd_log [$];
  logic [31:0] arg_log [$];

  sd_init_sequencer #(
    .INIT_CYCLES   (80),
    .RESP_TIMEOUT  (512),
    .ACMD41_RETRIES(4),
    .ACMD41_ARG    (32'h40FF_8000)
  ) dut (
    .iclk      (clk),
    .irst_n    (irst_n),
    .istart    (istart),
    .ocmd_start(ocmd_start),
    .ocmd_index(ocmd_index),
    .ocmd_arg  (ocmd_arg),
    .odrv_rst  (odrv_rst),
    .iresp     (iresp),
    .icmd_done (icmd_done),
    .oinit_done(oinit_done),
    .oerror    (oerror),
    .oerr_code (oerr_code),
    .orca      (orca),
    .ohcs      (ohcs)
  );

  always #5 clk = ~clk;

  // Driver + card model: done drops one cycle after the start pulse and
  // rises three cycles later for commands that get a response.
  always @(negedge clk) begin
    if (!irst_n) begin
      phase = 0;
      icmd_done = 1'b0;
    end else if (phase == 0) begin
      if (ocmd_start) begin
        cur_idx = ocmd_index;
        cur_arg = ocmd_arg;
        cmd_log.push_back(cur_idx);
        arg_log.push_back(cur_arg);
        if (cur_idx == 6'd0) a41_cnt = 0;
        phase = 1;
      end
    end else begin
      if (ocmd_index !== cur_idx || ocmd_arg !== cur_arg) stab_err++;
      case (phase)
        1: begin
          if (ocmd_start !== 1'b0) width_err++;
          icmd_done = 1'b0;
          phase = 2;
        end
        2, 3: phase++;
        4: begin
          phase = 5;
          case (cur_idx)
            6'd0: phase = 0;
            6'd8: begin
              iresp = {20'h0, cmd8_echo};
              if (!cmd8_respond) phase = 0;
            end
            6'd41: begin
              iresp = (always_busy || a41_cnt < busy_n) ? 32'h00FF_8000
                                                        : {1'b1, ccs, 30'h00FF_8000};
              a41_cnt++;
            end
            6'd3: iresp = {16'h1234, 16'h0500};
            default: iresp = 32'h0000_0900;
          endcase
          if (phase == 5) icmd_done = 1'b1;
        end
        default: phase = 0;
      endcase
    end
  end

  task automatic pulse_start();
    istart = 1'b1;
    @(negedge clk);
    @(negedge clk);
    istart = 1'b0;
  endtask

  task automatic test_reset();
    int cnt;
    irst_n = 1'b0;
    istart = 1'b0;
    repeat (4) @(negedge clk);
    total_cnt++; if (ocmd_start !== 1'b0) $display("FAIL rst_start: got %0b want 0", ocmd_start); else pass_cnt++;
    total_cnt++; if (ocmd_index !== 6'd0) $display("FAIL rst_index: got %0d want 0", ocmd_index); else pass_cnt++;
    total_cnt++; if (ocmd_arg !== 32'h0) $display("FAIL rst_arg: got %h want 0", ocmd_arg); else pass_cnt++;
    total_cnt++; if (odrv_rst !== 1'b1) $display("FAIL rst_drv_rst: got %0b want 1", odrv_rst); else pass_cnt++;
    total_cnt++; if (oinit_done !== 1'b0) $display("FAIL rst_done: got %0b want 0", oinit_done); else pass_cnt++;
    total_cnt++; if (oerror !== 1'b0) $display("FAIL rst_error: got %0b want 0", oerror); else pass_cnt++;
    total_cnt++; if (oerr_code !== 3'd0) $display("FAIL rst_code: got %0d want 0", oerr_code); else pass_cnt++;
    total_cnt++; if (orca !== 16'h0) $display("FAIL rst_rca: got %h want 0", orca); else pass_cnt++;
    total_cnt++; if (ohcs !== 1'b0) $display("FAIL rst_hcs: got %0b want 0", ohcs); else pass_cnt++;
    // Start requested immediately; it must be held until POWER_UP completes.
    irst_n = 1'b1;
    istart = 1'b1;
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      cnt++;
      if (i == 0) begin
        total_cnt++; if (odrv_rst !== 1'b0) $display("FAIL rst_release_drv: got %0b want 0", odrv_rst); else pass_cnt++;
      end
      if (ocmd_start) break;
    end
    istart = 1'b0;
    total_cnt++; if (cnt != 81) $display("FAIL powerup_wait: got %0d cycles want 81", cnt); else pass_cnt++;
  endtask

  task automatic test_normal();
    logic [5:0] exp_arr [11] = '{6'd0, 6'd8, 6'd55, 6'd41, 6'd55, 6'd41, 6'd55, 6'd41, 6'd2, 6'd3, 6'd7};
    logic [5:0] exp_seq [$];
    bit ok = 0;
    foreach (exp_arr[i]) exp_seq.push_back(exp_arr[i]);
`ifdef SD_INIT_WIDE_BUS_EN
    exp_seq.push_back(6'd55);
    exp_seq.push_back(6'd6);
`endif
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (oinit_done || oerror) begin ok = 1; break; end
    end
    total_cnt++; if (!ok) $display("FAIL normal_wait: no completion within 5000 cycles"); else pass_cnt++;
    total_cnt++; if (cmd_log.size() != exp_seq.size()) $display("FAIL normal_count: got %0d cmds want %0d", cmd_log.size(), exp_seq.size()); else pass_cnt++;
    foreach (exp_seq[i]) begin
      total_cnt++;
      if (i >= cmd_log.size() || cmd_log[i] !== exp_seq[i])
        $display("FAIL normal_seq[%0d]: got %0d want %0d", i, (i < cmd_log.size()) ? cmd_log[i] : 6'h3F, exp_seq[i]);
      else pass_cnt++;
    end
    if (arg_log.size() >= 11) begin
      total_cnt++; if (arg_log[1] !== 32'h0000_01AA) $display("FAIL cmd8_arg: got %h want 000001aa", arg_log[1]); else pass_cnt++;
      total_cnt++; if (arg_log[2] !== 32'h0) $display("FAIL cmd55_arg: got %h want 0", arg_log[2]); else pass_cnt++;
      total_cnt++; if (arg_log[3] !== 32'h40FF_8000) $display("FAIL acmd41_arg: got %h want 40ff8000", arg_log[3]); else pass_cnt++;
      total_cnt++; if (arg_log[10] !== 32'h1234_0000) $display("FAIL cmd7_arg: got %h want 12340000", arg_log[10]); else pass_cnt++;
    end else begin
      total_cnt++; $display("FAIL normal_args: only %0d args logged want 11", arg_log.size());
    end
    total_cnt++; if (oinit_done !== 1'b1) $display("FAIL normal_done: got %0b want 1", oinit_done); else pass_cnt++;
    total_cnt++; if (oerror !== 1'b0) $display("FAIL normal_error: got %0b want 0", oerror); else pass_cnt++;
    total_cnt++; if (orca !== 16'h1234) $display("FAIL normal_rca: got %h want 1234", orca); else pass_cnt++;
    total_cnt++; if (ohcs !== 1'b1) $display("FAIL normal_hcs: got %0b want 1", ohcs); else pass_cnt++;
    total_cnt++; if (oerr_code !== 3'd0) $display("FAIL normal_code: got %0d want 0", oerr_code); else pass_cnt++;
  endtask

  task automatic test_cmd8_mismatch();
    int base = cmd_log.size();
    bit ok = 0;
    cmd8_echo = 12'h0AA;
    pulse_start();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (oerror) begin ok = 1; break; end
    end
    total_cnt++; if (!ok) $display("FAIL echo_wait: oerror not set within 2000 cycles"); else pass_cnt++;
    total_cnt++; if (oerr_code !== 3'd2) $display("FAIL echo_code: got %0d want 2", oerr_code); else pass_cnt++;
    total_cnt++; if (oinit_done !== 1'b0) $display("FAIL echo_done: got %0b want 0", oinit_done); else pass_cnt++;
    repeat (50) @(negedge clk);
    total_cnt++; if (cmd_log.size() - base != 2) $display("FAIL echo_no_more_cmds: got %0d cmds want 2", cmd_log.size() - base); else pass_cnt++;
    total_cnt++; if (oerror !== 1'b1) $display("FAIL echo_sticky: got %0b want 1", oerror); else pass_cnt++;
  endtask

  task automatic test_cmd8_timeout();
    int cnt = 0;
    int wid = 0;
    bit found = 0;
    cmd8_echo = 12'h1AA;
    cmd8_respond = 1'b0;
    pulse_start();
    for (int i = 0; i < 2000; i++) begin
      if (ocmd_start && ocmd_index == 6'd8) begin found = 1; break; end
      @(negedge clk);
    end
    total_cnt++; if (!found) $display("FAIL tmo_cmd8_issue: CMD8 not issued within 2000 cycles"); else pass_cnt++;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      cnt++;
      if (odrv_rst) break;
    end
    total_cnt++; if (cnt != 512) $display("FAIL tmo_latency: got %0d cycles want 512", cnt); else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      if (!odrv_rst) break;
      wid++;
      @(negedge clk);
    end
    total_cnt++; if (wid != 2) $display("FAIL tmo_drv_rst_width: got %0d want 2", wid); else pass_cnt++;
    total_cnt++; if (oerror !== 1'b1) $display("FAIL tmo_error: got %0b want 1", oerror); else pass_cnt++;
    total_cnt++; if (oerr_code !== 3'd1) $display("FAIL tmo_code: got %0d want 1", oerr_code); else pass_cnt++;
    cmd8_respond = 1'b1;
  endtask

  task automatic test_acmd41_exhaust();
    int base = cmd_log.size();
    int n41 = 0;
    int n55 = 0;
    int n2 = 0;
    bit ok = 0;
    always_busy = 1'b1;
    pulse_start();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (oerror) begin ok = 1; break; end
    end
    for (int i = base; i < cmd_log.size(); i++) begin
      if (cmd_log[i] == 6'd41) n41++;
      if (cmd_log[i] == 6'd55) n55++;
      if (cmd_log[i] == 6'd2) n2++;
    end
    total_cnt++; if (!ok) $display("FAIL a41_wait: oerror not set within 3000 cycles"); else pass_cnt++;
    total_cnt++; if (oerr_code !== 3'd3) $display("FAIL a41_code: got %0d want 3", oerr_code); else pass_cnt++;
    total_cnt++; if (n41 != 4) $display("FAIL a41_attempts: got %0d want 4", n41); else pass_cnt++;
    total_cnt++; if (n55 != 4) $display("FAIL a41_cmd55s: got %0d want 4", n55); else pass_cnt++;
    total_cnt++; if (n2 != 0) $display("FAIL a41_no_cmd2: got %0d want 0", n2); else pass_cnt++;
    always_busy = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    bit ok = 0;
    int cnt = 0;
    busy_n = 1;
    pulse_start();
    for (int i = 0; i < 2000; i++) begin
      if (ocmd_start && ocmd_index == 6'd41) begin found = 1; break; end
      @(negedge clk);
    end
    total_cnt++; if (!found) $display("FAIL mid_acmd41_issue: ACMD41 not issued within 2000 cycles"); else pass_cnt++;
    @(negedge clk);
    @(negedge clk);
    total_cnt++; if (ocmd_index !== 6'd41) $display("FAIL mid_pre_index: got %0d want 41", ocmd_index); else pass_cnt++;
    irst_n = 1'b0;
    #1;
    total_cnt++; if (odrv_rst !== 1'b1) $display("FAIL mid_drv_rst: got %0b want 1", odrv_rst); else pass_cnt++;
    total_cnt++; if (ocmd_index !== 6'd0) $display("FAIL mid_index: got %0d want 0", ocmd_index); else pass_cnt++;
    total_cnt++; if (ocmd_arg !== 32'h0) $display("FAIL mid_arg: got %h want 0", ocmd_arg); else pass_cnt++;
    total_cnt++; if (ocmd_start !== 1'b0) $display("FAIL mid_start: got %0b want 0", ocmd_start); else pass_cnt++;
    total_cnt++; if (oinit_done !== 1'b0 || oerror !== 1'b0 || oerr_code !== 3'd0) $display("FAIL mid_flags: got done=%0b err=%0b code=%0d want 0/0/0", oinit_done, oerror, oerr_code); else pass_cnt++;
    repeat (3) @(negedge clk);
    irst_n = 1'b1;
    istart = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      cnt++;
      if (ocmd_start) break;
    end
    istart = 1'b0;
    total_cnt++; if (cnt != 81) $display("FAIL mid_powerup_wait: got %0d cycles want 81", cnt); else pass_cnt++;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (oinit_done || oerror) begin ok = 1; break; end
    end
    total_cnt++; if (!ok || oinit_done !== 1'b1) $display("FAIL mid_recover: got done=%0b want 1", oinit_done); else pass_cnt++;
    total_cnt++; if (orca !== 16'h1234) $display("FAIL mid_rca: got %h want 1234", orca); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int cnt = 0;
    bit ok = 0;
    ccs = 1'b0;
    busy_n = 0;
    istart = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      cnt++;
      if (ocmd_start) break;
    end
    istart = 1'b0;
    total_cnt++; if (cnt != 2) $display("FAIL b2b_restart_latency: got %0d cycles want 2", cnt); else pass_cnt++;
    total_cnt++; if (oinit_done !== 1'b0) $display("FAIL b2b_done_cleared: got %0b want 0", oinit_done); else pass_cnt++;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (oinit_done || oerror) begin ok = 1; break; end
    end
    total_cnt++; if (!ok || oinit_done !== 1'b1) $display("FAIL b2b_done: got %0b want 1", oinit_done); else pass_cnt++;
    total_cnt++; if (ohcs !== 1'b0) $display("FAIL b2b_hcs: got %0b want 0", ohcs); else pass_cnt++;
  endtask

  task automatic test_pulse_stability();
    total_cnt++; if (width_err != 0) $display("FAIL start_width: got %0d wide pulses want 0", width_err); else pass_cnt++;
    total_cnt++; if (stab_err != 0) $display("FAIL idx_arg_stable: got %0d changes want 0", stab_err); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_normal();
    test_cmd8_mismatch();
    test_cmd8_timeout();
    test_acmd41_exhaust();
    test_reset_mid();
    test_back_to_back();
    test_pulse_stability();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
